// File: rtl/filterbank_merge.sv
// filterbank_merge
//   Merges the even (0,2,..,30) and odd (1,3,..,31) filterbank-half outputs
//   into one ordered mel-coefficient stream E0,O0,E1,O1,...,E15,O15 with
//   ready/valid backpressure. Each half feeds its own first-word-fall-through
//   FIFO because neither half can be stalled mid-frame.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   en_i                enable; low clears all state at the next edge
//   even_data_i/_valid_i/_last_i   even-half coefficient, push strobe, frame end
//   odd_data_i/_valid_i/_last_i    odd-half coefficient, push strobe, frame end
//   data_o, valid_o, last_o        merged stream (data_o is 0 while invalid),
//                                  last_o marks coefficient 2*NUM_HALF-1
//   ready_i             downstream ready
//   overflow_o          sticky: a push was dropped on a full FIFO
//   frame_err_o         sticky: a half's push count at its last strobe was wrong
module filterbank_merge #(
    parameter int DATA_BW  = 32,
    parameter int NUM_HALF = 16,
    parameter int DEPTH    = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [DATA_BW-1:0] even_data_i,
    input  logic               even_valid_i,
    input  logic               even_last_i,
    input  logic [DATA_BW-1:0] odd_data_i,
    input  logic               odd_valid_i,
    input  logic               odd_last_i,
    output logic [DATA_BW-1:0] data_o,
    output logic               valid_o,
    output logic               last_o,
    input  logic               ready_i,
    output logic               overflow_o,
    output logic               frame_err_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int FRAME = 2 * NUM_HALF;
    localparam int CW    = $clog2(FRAME);

    typedef enum logic {
        PH_EVEN = 1'b0,
        PH_ODD  = 1'b1
    } phase_t;

    phase_t              sel, sel_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic                sel_idx;
    logic                xfer;
    logic [1:0]          push_req;
    logic [1:0]          last_in;
    logic [1:0]          empty;
    logic [DATA_BW-1:0]  in_data [2];
    logic [DATA_BW-1:0]  head    [2];

    assign push_req   = {odd_valid_i, even_valid_i} & {2{en_i}};
    assign last_in    = {odd_last_i, even_last_i} & {2{en_i}};
    assign in_data[0] = even_data_i;
    assign in_data[1] = odd_data_i;
    assign sel_idx    = (sel == PH_ODD);

    // Output path: combinational from registered state and en_i only.
    assign valid_o = en_i & ~empty[sel_idx];
    assign data_o  = valid_o ? head[sel_idx] : '0;
    assign last_o  = valid_o & (cnt == CW'(FRAME - 1));
    assign xfer    = valid_o & ready_i;

    // Index 0 is the even half, index 1 the odd half.
    for (genvar g = 0; g < 2; g++) begin : g_half
        logic [DATA_BW-1:0] mem [DEPTH];
        logic [AW:0]        wr_ptr, rd_ptr;
        logic [4:0]         fcnt, fcnt_inc;
        logic               full, pop, push_ok;
        logic               ovf, ferr;

        // Extra pointer MSB distinguishes full from empty.
        assign empty[g]  = (wr_ptr == rd_ptr);
        assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                           (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        assign head[g]   = mem[rd_ptr[AW-1:0]];
        assign pop       = xfer & (sel_idx == 1'(g));
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        assign push_ok   = push_req[g] & (~full | pop);
        // Dropped pushes still count towards the frame length.
        assign fcnt_inc  = fcnt + 5'(push_req[g]);

        always_ff @(posedge clk_i) begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= in_data[g];
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                fcnt   <= '0;
                ovf    <= 1'b0;
                ferr   <= 1'b0;
            end else if (!en_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                fcnt   <= '0;
                ovf    <= 1'b0;
                ferr   <= 1'b0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push_req[g] && full && !pop) begin
                    ovf <= 1'b1;
                end
                if (last_in[g]) begin
                    if (fcnt_inc != 5'(NUM_HALF)) begin
                        ferr <= 1'b1;
                    end
                    fcnt <= '0;
                end else begin
                    fcnt <= fcnt_inc;
                end
            end
        end
    end

    assign overflow_o  = g_half[0].ovf | g_half[1].ovf;
    assign frame_err_o = g_half[0].ferr | g_half[1].ferr;

    // Phase / coefficient counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sel <= PH_EVEN;
            cnt <= '0;
        end else begin
            sel <= sel_nxt;
            cnt <= cnt_nxt;
        end
    end

    always_comb begin
        sel_nxt = sel;
        cnt_nxt = cnt;
        if (!en_i) begin
            sel_nxt = PH_EVEN;
            cnt_nxt = '0;
        end else if (xfer) begin
            if (cnt == CW'(FRAME - 1)) begin
                sel_nxt = PH_EVEN;
                cnt_nxt = '0;
            end else begin
                sel_nxt = (sel == PH_EVEN) ? PH_ODD : PH_EVEN;
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

endmodule
